// File: rtl/joypad_controller_pkg.sv
// Shared constants and helpers for the joypad controller: P1 register
// address, button bit positions, counter sizing and the P1 nibble encoder.
package joypad_controller_pkg;

  localparam logic [15:0] P1_ADDR     = 16'hFF00;
  localparam int          NUM_BUTTONS = 8;

  // Button bit positions on the raw pin bus and in button_state
  localparam int BTN_RIGHT  = 0;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_UP     = 2;
  localparam int BTN_DOWN   = 3;
  localparam int BTN_A      = 4;
  localparam int BTN_B      = 5;
  localparam int BTN_SELECT = 6;
  localparam int BTN_START  = 7;

  typedef logic [1:0] sel_t;

  // Bits needed to count 0..cycles-1, never less than one
  function automatic int counter_width(input int cycles);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < cycles) w = i + 1;
    end
    return w;
  endfunction

  // Active-low P1 input nibble: a low select bit enables its button group,
  // and both groups are ORed when both selects are low
  function automatic logic [3:0] p1_nibble(input sel_t sel, input logic [7:0] state);
    logic [3:0] nib;
    for (int n = 0; n < 4; n++) begin
      nib[n] = ~((~sel[0] & state[n]) | (~sel[1] & state[n+4]));
    end
    return nib;
  endfunction

endpackage

// File: rtl/joypad_controller_if.sv
// CPU memory bus as seen by the joypad register block.
interface joypad_controller_if;
  logic [15:0] addr;
  logic [7:0]  data_in;
  logic        wr;
  logic        rd;
  logic [7:0]  data_out;

  modport master (output addr, output data_in, output wr, output rd, input data_out);
  modport slave  (input addr, input data_in, input wr, input rd, output data_out);
endinterface

// File: rtl/joypad_controller_button_filter.sv
// One button lane: two-flop synchroniser followed by a filter that only
// accepts a new level after two consecutive sample ticks agree on it.
module button_filter (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic state
);

  logic sync1_reg;
  logic sync2_reg;
  logic last_sample_reg;
  logic state_reg;

  // Synchronise the raw pin and update the filter on each sample tick
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_reg       <= 1'b0;
      sync2_reg       <= 1'b0;
      last_sample_reg <= 1'b0;
      state_reg       <= 1'b0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      if (tick) begin
        last_sample_reg <= sync2_reg;
        if (sync2_reg == last_sample_reg) state_reg <= sync2_reg;
      end
    end
  end

  assign state = state_reg;

endmodule

// File: rtl/joypad_controller.sv
// P1 joypad register block: shared debounce tick, eight filtered button
// lanes, the writable select bits, registered read port and the joypad
// interrupt on any falling line of the selected nibble.
module joypad_controller
  import joypad_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2000000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_BUTTONS-1:0]    buttons,
  joypad_controller_if.slave        bus,
  output logic                      joypad_irq,
  output logic [NUM_BUTTONS-1:0]    button_state
);

  localparam int              CNT_W   = counter_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             tick;
  sel_t             sel_reg;
  logic [7:0]       data_out_reg;
  logic [3:0]       nib;
  logic [3:0]       nib_q_reg;
  logic             irq_reg;
  logic             p1_hit;
  logic             unused_data_bits;

  // Sample tick counter: runs 0..DEBOUNCE_CYCLES-1 and ticks on the wrap cycle
  always_ff @(posedge clock) begin
    if (reset)     cnt_reg <= '0;
    else if (tick) cnt_reg <= '0;
    else           cnt_reg <= cnt_reg + 1'b1;
  end

  assign tick = (cnt_reg == CNT_MAX);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BUTTONS; gi++) begin : g_filter
      button_filter u_filter (
        .clock (clock),
        .reset (reset),
        .tick  (tick),
        .raw   (buttons[gi]),
        .state (button_state[gi])
      );
    end
  endgenerate

  assign p1_hit = (bus.addr == P1_ADDR);
  assign nib    = p1_nibble(sel_reg, button_state);

  // Only the select bits of P1 are writable
  always_ff @(posedge clock) begin
    if (reset)               sel_reg <= 2'b11;
    else if (bus.wr && p1_hit) sel_reg <= bus.data_in[5:4];
  end

  // Registered read port; reads see the select value from before a same-cycle write
  always_ff @(posedge clock) begin
    if (reset)       data_out_reg <= 8'hFF;
    else if (bus.rd) data_out_reg <= p1_hit ? {2'b11, sel_reg, nib} : 8'hFF;
  end

  // Interrupt on any high-to-low transition of the selected nibble, including select changes
  always_ff @(posedge clock) begin
    if (reset) begin
      nib_q_reg <= 4'hF;
      irq_reg   <= 1'b0;
    end else begin
      nib_q_reg <= nib;
      irq_reg   <= |(nib_q_reg & ~nib);
    end
  end

  assign bus.data_out     = data_out_reg;
  assign joypad_irq       = irq_reg;
  assign unused_data_bits = ^{bus.data_in[7:6], bus.data_in[3:0]};

endmodule
